// File: rtl/game_pkg.sv
// Shared memory-game definitions: sizes, player FSM states and the
// level-to-length rule used by both the pattern player and the input capture.
package game_pkg;

   localparam int MAX_STEPS = 16;
   localparam int IDX_W     = 3;
   localparam int LEVEL_W   = 3;
   localparam int STEP_W    = 5;
   localparam int NUM_LEDS  = 8;
   localparam int PAT_W     = MAX_STEPS * IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_GAP,
      ST_DONE
   } player_state_e;

   // Sequence length 4*level+4, clamped to 16; levels 0..2 fit in 5 bits with
   // no overflow, everything above saturates.
   function automatic logic [STEP_W-1:0] seq_len(input logic [LEVEL_W-1:0] level);
      logic [STEP_W-1:0] n;
      if (level >= LEVEL_W'(3)) n = STEP_W'(MAX_STEPS);
      else                      n = STEP_W'({level[1:0], 2'b00}) + STEP_W'(4);
      return n;
   endfunction

endpackage

// File: rtl/pattern_player_if.sv
// Request/display bundle of the pattern player. The game controller drives
// the master side, the player implements the slave side.
interface pattern_player_if;
   import game_pkg::*;

   logic                  start;
   logic [LEVEL_W-1:0]    level;
   logic [PAT_W-1:0]      pattern;
   logic [NUM_LEDS-1:0]   led;
   logic                  busy;
   logic [STEP_W-1:0]     step;
   logic                  done;

   modport master (
      output start, level, pattern,
      input  led, busy, step, done
   );

   modport slave (
      input  start, level, pattern,
      output led, busy, step, done
   );

endinterface

// File: rtl/pattern_player_idx_to_onehot.sv
// Button index to one-hot LED decode (index v lights LED bit v), combinational.
module idx_to_onehot
   import game_pkg::*;
(
   input  logic [IDX_W-1:0]    idx_i,
   input  logic                en_i,
   output logic [NUM_LEDS-1:0] onehot_o
);

   // Light exactly one LED when enabled, none otherwise
   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/pattern_player.sv
// Memory-game pattern player: latches a sequence of button indices on start
// and shows them one at a time on the LEDs with fixed on/off dwell times.
// Optional feature macro: PATTERN_PLAYER_ABORT_EN adds an abort input that
// drops an in-progress playback back to IDLE without a done pulse.
module pattern_player
   import game_pkg::*;
#(
   parameter int ON_CYCLES  = 50_000_000,
   parameter int OFF_CYCLES = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PATTERN_PLAYER_ABORT_EN
   input  logic             abort,
`endif
   pattern_player_if.slave  bus
);

   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   player_state_e                    state_q, state_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [STEP_W-1:0]                step_q, step_d;
   logic [STEP_W-1:0]                len_q, len_d;
   logic [MAX_STEPS-1:0][IDX_W-1:0]  shadow_q, shadow_d;
   logic [NUM_LEDS-1:0]              led_q, led_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;
   logic                             abort_w;

`ifdef PATTERN_PLAYER_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Next-state logic; the dwell counter is cleared on every state change
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      len_d    = len_q;
      shadow_d = shadow_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               shadow_d = bus.pattern;
               len_d    = seq_len(bus.level);
               step_d   = '0;
               cnt_d    = '0;
               state_d  = ST_ON;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_ON: begin
            if (abort_w) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               step_d  = '0;
            end else if (cnt_q == ON_LAST) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (abort_w) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               step_d  = '0;
            end else if (cnt_q == OFF_LAST) begin
               cnt_d = '0;
               if (step_q == len_q - STEP_W'(1)) begin
                  // step reads 0 outside playback, so it clears on the way out
                  step_d  = '0;
                  state_d = ST_DONE;
               end else begin
                  step_d  = step_q + STEP_W'(1);
                  state_d = ST_ON;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are computed from the next state so they can be registered
      // and still line up with the state they describe.
      busy_d = (state_d == ST_ON) || (state_d == ST_GAP);
      done_d = (state_d == ST_DONE);
   end

   idx_to_onehot u_led_dec (
      .idx_i    (shadow_d[step_d[3:0]]),
      .en_i     (state_d == ST_ON),
      .onehot_o (led_d)
   );

   // State and registered outputs, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         step_q   <= '0;
         len_q    <= '0;
         shadow_q <= '0;
         led_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         len_q    <= len_d;
         shadow_q <= shadow_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.led  = led_q;
   assign bus.busy = busy_q;
   assign bus.step = step_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Scoreboard bench for pattern_player with ON_CYCLES=4, OFF_CYCLES=2.
// Expected per-cycle outputs are queued when start is driven and popped on
// each falling clock edge.
module tb_pattern_player;
   import game_pkg::*;

   localparam int ON_C  = 4;
   localparam int OFF_C = 2;

   typedef struct packed {
      logic [7:0] led;
      logic       busy;
      logic [4:0] step;
      logic       done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef PATTERN_PLAYER_ABORT_EN
   logic abort = 1'b0;
`endif

   pattern_player_if bus();

   pattern_player #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef PATTERN_PLAYER_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;

   function automatic int len_of(input int lvl);
      return (lvl >= 3) ? 16 : 4 * lvl + 4;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.led = bus.led; o.busy = bus.busy; o.step = bus.step; o.done = bus.done;
      return o;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("led=%h busy=%b step=%0d done=%b", e.led, e.busy, e.step, e.done);
   endfunction

   // Queue the full expected playback of n slots followed by the done cycle
   task automatic push_play(input logic [47:0] pat, input int n);
      exp_t e;
      logic [2:0] v;
      for (int s = 0; s < n; s++) begin
         v = pat[3*s +: 3];
         for (int c = 0; c < ON_C; c++) begin
            e.led = 8'd1 << v; e.busy = 1'b1; e.step = 5'(s); e.done = 1'b0;
            exp_q.push_back(e);
         end
         for (int c = 0; c < OFF_C; c++) begin
            e.led = 8'd0; e.busy = 1'b1; e.step = 5'(s); e.done = 1'b0;
            exp_q.push_back(e);
         end
      end
      e = '0; e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic push_idle(input int n);
      repeat (n) exp_q.push_back('0);
   endtask

   task automatic test_reset();
      exp_t e, o;
      int i = 0;
      bus.start = 1'b0; bus.level = '0; bus.pattern = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      push_idle(10);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) $display("FAIL reset c%0d got %s want %s", i, fmt(o), fmt(e));
         else passes++;
         i++;
      end
   endtask

   task automatic test_level1();
      exp_t e, o;
      int i = 0;
      logic [47:0] p = 48'({$urandom(), $urandom()});
      for (int v = 0; v < 8; v++) p[3*v +: 3] = 3'(v);
      bus.pattern = p; bus.level = 3'd1; bus.start = 1'b1;
      push_play(p, len_of(1));
      push_idle(3);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) $display("FAIL level1 c%0d got %s want %s", i, fmt(o), fmt(e));
         else passes++;
         if (i == 0) bus.start = 1'b0;
         i++;
      end
   endtask

   task automatic test_lengths();
      exp_t e, o;
      logic [47:0] p;
      int lv[2] = '{0, 5};
      for (int k = 0; k < 2; k++) begin
         int i = 0;
         p = 48'({$urandom(), $urandom()});
         bus.pattern = p; bus.level = 3'(lv[k]); bus.start = 1'b1;
         push_play(p, len_of(lv[k]));
         push_idle(2);
         while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front(); o = observe(); checks++;
            if (o !== e) $display("FAIL len_lvl%0d c%0d got %s want %s", lv[k], i, fmt(o), fmt(e));
            else passes++;
            if (i == 0) bus.start = 1'b0;
            i++;
         end
      end
   endtask

   // start stays high: no retrigger while busy, one done, immediate restart;
   // the pattern change mid-play only shows up in the second playback
   task automatic test_back_to_back();
      exp_t e, o;
      int i = 0;
      int n = len_of(2);
      logic [47:0] pa = 48'({$urandom(), $urandom()});
      logic [47:0] pb = ~pa;
      bus.pattern = pa; bus.level = 3'd2; bus.start = 1'b1;
      push_play(pa, n);
      push_play(pb, n);
      push_idle(2);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) $display("FAIL back_to_back c%0d got %s want %s", i, fmt(o), fmt(e));
         else passes++;
         if (i == 10) bus.pattern = pb;
         if (i == n * (ON_C + OFF_C) + 10) bus.start = 1'b0;
         i++;
      end
   endtask

   // rst during the first GAP cycle of step 3, then a normal playback
   task automatic test_rst_mid();
      exp_t e, o;
      int i = 0;
      logic [47:0] p = 48'({$urandom(), $urandom()});
      logic [47:0] q = 48'({$urandom(), $urandom()});
      bus.pattern = p; bus.level = 3'd1; bus.start = 1'b1;
      push_play(p, len_of(1));
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) $display("FAIL rst_mid c%0d got %s want %s", i, fmt(o), fmt(e));
         else passes++;
         if (i == 0) bus.start = 1'b0;
         if (i == 22) begin rst = 1'b1; exp_q.delete(); push_idle(20); end
         if (i == 23) rst = 1'b0;
         if (i == 42) begin
            bus.pattern = q; bus.level = 3'd0; bus.start = 1'b1;
            push_play(q, len_of(0)); push_idle(2);
         end
         if (i == 43) bus.start = 1'b0;
         i++;
      end
   endtask

`ifdef PATTERN_PLAYER_ABORT_EN
   // abort in the second ON cycle of step 2, then replay from step 0
   task automatic test_abort();
      exp_t e, o;
      int i = 0;
      logic [47:0] p = 48'({$urandom(), $urandom()});
      logic [47:0] q = 48'({$urandom(), $urandom()});
      bus.pattern = p; bus.level = 3'd1; bus.start = 1'b1;
      push_play(p, len_of(1));
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); o = observe(); checks++;
         if (o !== e) $display("FAIL abort c%0d got %s want %s", i, fmt(o), fmt(e));
         else passes++;
         if (i == 0) bus.start = 1'b0;
         if (i == 13) begin abort = 1'b1; exp_q.delete(); push_idle(20); end
         if (i == 14) abort = 1'b0;
         if (i == 33) begin
            bus.pattern = q; bus.level = 3'd0; bus.start = 1'b1;
            push_play(q, len_of(0)); push_idle(2);
         end
         if (i == 34) bus.start = 1'b0;
         i++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_level1();
      test_lengths();
      test_back_to_back();
      test_rst_mid();
`ifdef PATTERN_PLAYER_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
